johnson_phase_monitor: RTL and testbench
========================================

JOHNSON_PHASE_MONITOR -- requirements
Module: johnson_phase_monitor

Interface
REQ-001 Parameter: CNT_W, 8, width of revolution counter rev_cnt.
REQ-002 clk  input  1  system clock, all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset; asserted (0) clears all state immediately, independent of clk.
REQ-004 q_in  input  8  Johnson count from the upstream 8-bit Johnson counter, sampled every rising edge.
REQ-005 clr_err  input  1  synchronous clear of err_sticky.
REQ-006 phase  output  4  decoded phase index 0..15, registered.
REQ-007 phase_oh  output  16  one-hot of phase, all-zero when valid=0.
REQ-008 valid  output  1  monitor locked and phase meaningful.
REQ-009 step_err  output  1  one-cycle pulse on illegal code or illegal step.
REQ-010 err_sticky  output  1  set by any step_err, held until clr_err.
REQ-011 rev_pulse  output  1  one-cycle pulse on each completed revolution.
REQ-012 rev_cnt  output  CNT_W  count of completed revolutions.

Function
REQ-013 Legal codes SHALL be the 16 Johnson states of next={q[6:0],~q[7]}: phase k (0..8) = (2^k)-1; phase k (9..15) = 8'hFF shifted left by (k-8), i.e. 9=8'hFE, 15=8'h80.
REQ-014 Any other q_in value SHALL be illegal.
REQ-015 All outputs SHALL be registered; an input sampled at edge N is reflected after edge N (latency 1 cycle).
REQ-016 FSM states SHALL be SYNC and TRACK.
REQ-017 SYNC: valid=0, phase=0; legal code -> TRACK with phase=decoded index, no rev_pulse, no step_err; illegal code -> stay SYNC, no step_err.
REQ-018 TRACK, q_in equal to current phase code (hold): no change, no pulses.
REQ-019 TRACK, q_in = phase+1 mod 16: phase advances; transition 15->0 asserts rev_pulse and increments rev_cnt.
REQ-020 TRACK, legal code other than hold or +1 (skip/reverse): step_err pulse, stay TRACK, phase resyncs to decoded index, no rev_pulse.
REQ-021 TRACK, illegal code: step_err pulse, -> SYNC, valid=0, phase_oh=0.
REQ-022 rev_cnt SHALL wrap from 2^CNT_W-1 to 0 without flag.
REQ-023 err_sticky set and clr_err in same cycle: set wins.

Reset
REQ-024 rst=0 SHALL asynchronously force state=SYNC, phase=0, phase_oh=0, valid=0, step_err=0, err_sticky=0, rev_pulse=0, rev_cnt=0.
REQ-025 Reset mid-revolution SHALL discard progress; after release, next legal code relocks without counting a revolution.

Configuration
REQ-026 Macro JOHNSON_REV_CNT_EN defined: rev_cnt and rev_pulse implemented per REQ-019/022.
REQ-027 Macro JOHNSON_REV_CNT_EN undefined: rev_cnt tied to 0, rev_pulse tied to 0, no counter flops; all other behaviour unchanged.

Structure
REQ-028 Shared package johnson_pkg SHALL hold: JW=8, NPHASE=16, state typedef {SYNC, TRACK}.
REQ-029 Combinational sub-module johnson_code2phase SHALL map q_in to {legal, index[3:0]}; monitor instantiates it once.

Verification
REQ-030 Reset: rst=0 while q_in=8'h0F -> all outputs 0, valid=0; rst=1 -> next edge valid=1, phase=4.
REQ-031 Drive upstream counter for 32 cycles from 8'h00 -> phase 0..15 twice, rev_pulse twice, rev_cnt=2, step_err never.
REQ-032 Locked at phase 3 (8'h07), drive 8'h1F (phase 5) -> step_err pulse, err_sticky=1, phase=5, valid=1.
REQ-033 Locked, drive 8'h05 -> step_err pulse, valid=0, phase_oh=0; then 8'h01 -> valid=1, phase=1, no rev_pulse.
REQ-034 err_sticky=1, clr_err=1 same cycle as new illegal code -> err_sticky stays 1; next cycle clr_err=1 alone -> 0.
REQ-035 CNT_W=2, 5 revolutions -> rev_cnt sequence 1,2,3,0,1; rebuild without JOHNSON_REV_CNT_EN -> rev_cnt=0 throughout.

Source files
------------

// File: rtl/johnson_pkg.sv
// Shared definitions for the Johnson phase monitor.
// Holds the Johnson counter width, phase count, FSM state type, decoder
// result struct and a helper that returns the legal code for a phase index.
package johnson_pkg;

  localparam int JW     = 8;
  localparam int NPHASE = 16;
  localparam int PH_W   = $clog2(NPHASE);

  typedef enum logic {
    SYNC  = 1'b0,
    TRACK = 1'b1
  } state_t;

  // Decoder result: legal flag plus phase index (index is 0 when illegal).
  typedef struct packed {
    logic            legal;
    logic [PH_W-1:0] idx;
  } code_t;

  // Phases 0..JW fill ones from the LSB side. Phases JW+1..2*JW-1 shift
  // zeros in from the LSB side.
  function automatic logic [JW-1:0] johnson_code(input int k);
    logic [JW-1:0] ones;
    ones = '1;
    if (k <= JW) return ones >> (JW - k);
    else         return ones << (k - JW);
  endfunction

endpackage

// File: rtl/johnson_code2phase.sv
// Combinational Johnson code decoder.
// Ports:
//   q_in  : JW-bit code from the upstream Johnson counter
//   code  : {legal, idx} -- legal=1 when q_in is one of the NPHASE codes
import johnson_pkg::*;

module johnson_code2phase (
  input  logic [JW-1:0] q_in,
  output code_t         code
);

  logic [NPHASE-1:0] w_hit;

  genvar k;
  generate
    for (k = 0; k < NPHASE; k++) begin : g_cmp
      assign w_hit[k] = (q_in == johnson_code(k));
    end
  endgenerate

  // Johnson codes are distinct, so at most one bit of w_hit is set.
  always_comb begin
    code = '0;
    for (int i = 0; i < NPHASE; i++) begin
      if (w_hit[i]) begin
        code.legal = 1'b1;
        code.idx   = PH_W'(i);
      end
    end
  end

endmodule

// File: rtl/johnson_phase_monitor.sv
// Johnson counter phase monitor.
// Locks onto the upstream Johnson count, tracks phase, flags illegal codes
// and illegal steps, and optionally counts completed revolutions.
// Configuration macro: JOHNSON_REV_CNT_EN -- when defined, rev_pulse and
// rev_cnt are implemented; when undefined both are tied to 0.
// Ports:
//   clk        : clock, rising edge
//   rst        : async active-low reset
//   q_in       : Johnson code input, sampled every edge
//   clr_err    : synchronous clear of err_sticky (a new error wins)
//   phase      : registered phase index
//   phase_oh   : one-hot of phase, zero when not valid
//   valid      : locked (TRACK)
//   step_err   : one-cycle pulse on illegal code / illegal step while locked
//   err_sticky : latched step_err
//   rev_pulse  : one-cycle pulse on 15->0 advance
//   rev_cnt    : completed revolutions, wraps silently
import johnson_pkg::*;

module johnson_phase_monitor #(
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [JW-1:0]     q_in,
  input  logic              clr_err,
  output logic [PH_W-1:0]   phase,
  output logic [NPHASE-1:0] phase_oh,
  output logic              valid,
  output logic              step_err,
  output logic              err_sticky,
  output logic              rev_pulse,
  output logic [CNT_W-1:0]  rev_cnt
);

  code_t             w_code;
  state_t            r_state, w_state_nxt;
  logic [PH_W-1:0]   r_phase, w_phase_nxt, w_phase_inc;
  logic [NPHASE-1:0] r_phase_oh, w_oh_nxt;
  logic              r_step_err, w_step_err_nxt;
  logic              r_err_sticky, w_sticky_nxt;

  johnson_code2phase u_dec (
    .q_in (q_in),
    .code (w_code)
  );

  assign w_phase_inc = r_phase + PH_W'(1);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= SYNC;
    else      r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      SYNC:    if (w_code.legal)  w_state_nxt = TRACK;
      TRACK:   if (!w_code.legal) w_state_nxt = SYNC;
      default: w_state_nxt = SYNC;
    endcase
  end

  // Output logic (next values of the registered outputs)
  always_comb begin
    w_phase_nxt    = r_phase;
    w_step_err_nxt = 1'b0;
    case (r_state)
      SYNC: begin
        // Illegal codes while unlocked are not errors: we are still searching.
        w_phase_nxt = w_code.legal ? w_code.idx : '0;
      end
      TRACK: begin
        if (!w_code.legal) begin
          w_step_err_nxt = 1'b1;
          w_phase_nxt    = '0;
        end else if (w_code.idx != r_phase) begin
          // Anything but hold or +1 is a skip/reverse: resync to the code.
          w_step_err_nxt = (w_code.idx != w_phase_inc);
          w_phase_nxt    = w_code.idx;
        end
      end
      default: w_phase_nxt = '0;
    endcase
    w_oh_nxt     = (w_state_nxt == TRACK) ? (NPHASE'(1) << w_phase_nxt) : '0;
    w_sticky_nxt = w_step_err_nxt ? 1'b1 : (clr_err ? 1'b0 : r_err_sticky);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_phase      <= '0;
      r_phase_oh   <= '0;
      r_step_err   <= 1'b0;
      r_err_sticky <= 1'b0;
    end else begin
      r_phase      <= w_phase_nxt;
      r_phase_oh   <= w_oh_nxt;
      r_step_err   <= w_step_err_nxt;
      r_err_sticky <= w_sticky_nxt;
    end
  end

  assign phase      = r_phase;
  assign phase_oh   = r_phase_oh;
  assign valid      = (r_state == TRACK);
  assign step_err   = r_step_err;
  assign err_sticky = r_err_sticky;

`ifdef JOHNSON_REV_CNT_EN
  logic             w_rev_nxt;
  logic             r_rev_pulse;
  logic [CNT_W-1:0] r_rev_cnt;

  // Only a legal +1 step from the last phase completes a revolution; a
  // relock at phase 0 from SYNC or a skip to 0 does not.
  assign w_rev_nxt = (r_state == TRACK) && w_code.legal &&
                     (r_phase == PH_W'(NPHASE-1)) && (w_code.idx == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rev_pulse <= 1'b0;
      r_rev_cnt   <= '0;
    end else begin
      r_rev_pulse <= w_rev_nxt;
      if (w_rev_nxt) r_rev_cnt <= r_rev_cnt + CNT_W'(1);
    end
  end

  assign rev_pulse = r_rev_pulse;
  assign rev_cnt   = r_rev_cnt;
`else
  assign rev_pulse = 1'b0;
  assign rev_cnt   = '0;
`endif

endmodule

// File: tb/tb_johnson_phase_monitor.sv
module tb_johnson_phase_monitor;

`ifdef JOHNSON_REV_CNT_EN
  localparam bit REV_EN = 1'b1;
`else
  localparam bit REV_EN = 1'b0;
`endif

  logic        clk, rst, clr_err;
  logic [7:0]  q_in;
  logic [3:0]  phase, phase2;
  logic [15:0] phase_oh, phase_oh2;
  logic        valid, step_err, err_sticky, rev_pulse;
  logic        valid2, step_err2, err_sticky2, rev_pulse2;
  logic [7:0]  rev_cnt;
  logic [1:0]  rev_cnt2;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] tbl [16] = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F,
                           8'hFF, 8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80};

  johnson_phase_monitor #(.CNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .q_in(q_in), .clr_err(clr_err),
    .phase(phase), .phase_oh(phase_oh), .valid(valid), .step_err(step_err),
    .err_sticky(err_sticky), .rev_pulse(rev_pulse), .rev_cnt(rev_cnt)
  );

  johnson_phase_monitor #(.CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .q_in(q_in), .clr_err(clr_err),
    .phase(phase2), .phase_oh(phase_oh2), .valid(valid2), .step_err(step_err2),
    .err_sticky(err_sticky2), .rev_pulse(rev_pulse2), .rev_cnt(rev_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [7:0] q, input logic clr);
    @(negedge clk);
    q_in    = q;
    clr_err = clr;
    @(posedge clk);
    #1;
  endtask

  int n_rev, n_serr, revn;
  logic [3:0] k;

  initial begin
    rst = 1'b1; q_in = 8'h0F; clr_err = 1'b0;
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_phase", phase, 0);
    chk("rst_oh", phase_oh, 0);
    chk("rst_valid", valid, 0);
    chk("rst_serr", step_err, 0);
    chk("rst_sticky", err_sticky, 0);
    chk("rst_revp", rev_pulse, 0);
    chk("rst_revcnt", rev_cnt, 0);
    chk("rst_revcnt2", rev_cnt2, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("lock_valid", valid, 1);
    chk("lock_phase", phase, 4);
    chk("lock_oh", phase_oh, 16'h0010);
    chk("lock_serr", step_err, 0);

    // relock at phase 0, then run two full revolutions
    @(negedge clk); rst = 1'b0; q_in = 8'h00;
    #1 chk("rst2_valid", valid, 0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("relock0_phase", phase, 0);
    chk("relock0_valid", valid, 1);
    n_rev = 0; n_serr = 0;
    for (int i = 0; i < 32; i++) begin
      k = 4'((i + 1) % 16);
      step(tbl[k], 1'b0);
      chk("run_phase", phase, 32'(k));
      chk("run_revp", rev_pulse, (REV_EN && k == 0) ? 1 : 0);
      if (rev_pulse) n_rev++;
      if (step_err) n_serr++;
    end
    chk("run_nrev", n_rev, REV_EN ? 2 : 0);
    chk("run_nserr", n_serr, 0);
    chk("run_revcnt", rev_cnt, REV_EN ? 2 : 0);
    chk("run_revcnt2", rev_cnt2, REV_EN ? 2 : 0);

    // skip from phase 3 to phase 5
    step(8'h01, 1'b0); step(8'h03, 1'b0); step(8'h07, 1'b0);
    chk("pre_skip_phase", phase, 3);
    chk("pre_skip_serr", step_err, 0);
    step(8'h1F, 1'b0);
    chk("skip_serr", step_err, 1);
    chk("skip_sticky", err_sticky, 1);
    chk("skip_phase", phase, 5);
    chk("skip_valid", valid, 1);
    step(8'h1F, 1'b0);
    chk("hold_serr", step_err, 0);
    chk("hold_sticky", err_sticky, 1);
    chk("hold_phase", phase, 5);

    // illegal code with simultaneous clr_err: set wins
    step(8'h05, 1'b1);
    chk("ill_serr", step_err, 1);
    chk("ill_valid", valid, 0);
    chk("ill_oh", phase_oh, 0);
    chk("ill_sticky", err_sticky, 1);
    step(8'h05, 1'b1);
    chk("sync_ill_serr", step_err, 0);
    chk("clr_sticky", err_sticky, 0);
    chk("sync_valid", valid, 0);
    step(8'h01, 1'b0);
    chk("relock1_valid", valid, 1);
    chk("relock1_phase", phase, 1);
    chk("relock1_oh", phase_oh, 16'h0002);
    chk("relock1_serr", step_err, 0);
    chk("relock1_revp", rev_pulse, 0);

    // reverse 1->0 is an error, not a revolution
    step(8'h00, 1'b0);
    chk("rev_serr", step_err, 1);
    chk("rev_phase", phase, 0);
    chk("rev_revp", rev_pulse, 0);
    step(8'h80, 1'b0);
    chk("skip15_serr", step_err, 1);
    chk("skip15_phase", phase, 15);

    // mid-revolution reset, relock at 0 without counting
    @(negedge clk); rst = 1'b0; q_in = 8'h00;
    #1;
    chk("mrst_valid", valid, 0);
    chk("mrst_phase", phase, 0);
    chk("mrst_revcnt", rev_cnt, 0);
    chk("mrst_sticky", err_sticky, 0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("mrel_valid", valid, 1);
    chk("mrel_phase", phase, 0);
    chk("mrel_revp", rev_pulse, 0);
    chk("mrel_revcnt", rev_cnt, 0);

    // five revolutions: 2-bit counter wraps 1,2,3,0,1
    revn = 0;
    for (int i = 0; i < 80; i++) begin
      k = 4'((i + 1) % 16);
      step(tbl[k], 1'b0);
      if (k == 0) begin
        revn++;
        chk("r5_revp", rev_pulse2, REV_EN ? 1 : 0);
        chk("r5_revcnt2", rev_cnt2, REV_EN ? (revn % 4) : 0);
        chk("r5_revcnt", rev_cnt, REV_EN ? revn : 0);
      end
    end
    chk("r5_serr", err_sticky, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
